// File: rtl/multicycle_controller.sv
// Main control FSM for the multicycle RV32I core, with a req/ready memory handshake and timeout.
// Optional build macro ILLEGAL_OP_TRAP_EN: unknown opcodes trap to FAULT instead of acting as NOPs.
module multicycle_controller #(
  parameter int unsigned MEM_WAIT_MAX = 15,
  parameter int unsigned WAIT_CNT_W   = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [6:0] op_i,
  input  logic [2:0] funct3_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output logic       mem_req_o,
  output logic       mem_write_o,
  output logic       adr_src_o,
  output logic       ir_write_o,
  output logic       pc_write_o,
  output logic       reg_write_o,
  output logic [1:0] result_src_o,
  output logic [1:0] alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] imm_src_o,
  output logic [1:0] alu_op_o,
  output logic       instr_done_o,
  output logic       mem_err_o,
  output logic       illegal_op_o
);

  typedef enum logic [3:0] {
    StRst, StFetch, StDecode, StMemAdr, StMemRead, StMemWb, StMemWrite,
    StExecR, StExecI, StAluWb, StBranch, StJal, StFault
  } state_e;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [WAIT_CNT_W-1:0] WaitMax = WAIT_CNT_W'(MEM_WAIT_MAX);

  state_e                state_q, state_d;
  logic [WAIT_CNT_W-1:0] wait_q, wait_d;
  logic                  mem_err_q, mem_err_d;
  logic                  timeout;
  logic                  op_known;
  logic                  unused_funct3;

  assign unused_funct3 = ^funct3_i[2:1];
  assign op_known = (op_i == OpLoad) || (op_i == OpStore) || (op_i == OpR) ||
                    (op_i == OpImm) || (op_i == OpBranch) || (op_i == OpJal);
  // The ready cycle always wins over an expiring wait budget.
  assign timeout = (MEM_WAIT_MAX != 0) && (wait_q == WaitMax) && !mem_ready_i;

`ifdef ILLEGAL_OP_TRAP_EN
  logic illegal_q, illegal_d;
  assign illegal_op_o = illegal_q;
`else
  assign illegal_op_o = 1'b0;
`endif
  assign mem_err_o = mem_err_q;

  always_comb begin
    state_d   = state_q;
    mem_err_d = mem_err_q;
`ifdef ILLEGAL_OP_TRAP_EN
    illegal_d = illegal_q;
`endif
    case (state_q)
      StRst:    state_d = StFetch;
      StFetch: begin
        if (mem_ready_i) begin
          state_d = StDecode;
        end else if (timeout) begin
          state_d   = StFault;
          mem_err_d = 1'b1;
        end
      end
      StDecode: begin
        case (op_i)
          OpLoad, OpStore: state_d = StMemAdr;
          OpR:             state_d = StExecR;
          OpImm:           state_d = StExecI;
          OpBranch:        state_d = StBranch;
          OpJal:           state_d = StJal;
          default: begin
`ifdef ILLEGAL_OP_TRAP_EN
            state_d   = StFault;
            illegal_d = 1'b1;
`else
            state_d = StFetch;
`endif
          end
        endcase
      end
      StMemAdr: state_d = op_i[5] ? StMemWrite : StMemRead;
      StMemRead: begin
        if (mem_ready_i) begin
          state_d = StMemWb;
        end else if (timeout) begin
          state_d   = StFault;
          mem_err_d = 1'b1;
        end
      end
      StMemWrite: begin
        if (mem_ready_i) begin
          state_d = StFetch;
        end else if (timeout) begin
          state_d   = StFault;
          mem_err_d = 1'b1;
        end
      end
      StMemWb, StAluWb, StBranch: state_d = StFetch;
      StExecR, StExecI, StJal:    state_d = StAluWb;
      StFault:                    state_d = StFault;
      default:                    state_d = StRst;
    endcase

    // Counter only runs while a single access is stalled; any state change restarts it.
    if ((state_d != state_q) || mem_ready_i || !mem_req_o) begin
      wait_d = '0;
    end else begin
      wait_d = wait_q + WAIT_CNT_W'(1);
    end
  end

  always_comb begin
    mem_req_o    = 1'b0;
    mem_write_o  = 1'b0;
    adr_src_o    = 1'b0;
    ir_write_o   = 1'b0;
    pc_write_o   = 1'b0;
    reg_write_o  = 1'b0;
    result_src_o = 2'b00;
    alu_src_a_o  = 2'b00;
    alu_src_b_o  = 2'b00;
    alu_op_o     = 2'b00;
    instr_done_o = 1'b0;
    case (state_q)
      StFetch: begin
        mem_req_o    = 1'b1;
        alu_src_b_o  = 2'b10;
        result_src_o = 2'b10;
        ir_write_o   = mem_ready_i;
        pc_write_o   = mem_ready_i;
      end
      StDecode: begin
        alu_src_a_o = 2'b01;
        alu_src_b_o = 2'b01;
`ifndef ILLEGAL_OP_TRAP_EN
        instr_done_o = !op_known;
`endif
      end
      StMemAdr: begin
        alu_src_a_o = 2'b10;
        alu_src_b_o = 2'b01;
      end
      StMemRead: begin
        mem_req_o = 1'b1;
        adr_src_o = 1'b1;
      end
      StMemWb: begin
        result_src_o = 2'b01;
        reg_write_o  = 1'b1;
        instr_done_o = 1'b1;
      end
      StMemWrite: begin
        mem_req_o    = 1'b1;
        mem_write_o  = 1'b1;
        adr_src_o    = 1'b1;
        instr_done_o = mem_ready_i;
      end
      StExecR: begin
        alu_src_a_o = 2'b10;
        alu_op_o    = 2'b10;
      end
      StExecI: begin
        alu_src_a_o = 2'b10;
        alu_src_b_o = 2'b01;
        alu_op_o    = 2'b10;
      end
      StAluWb: begin
        reg_write_o  = 1'b1;
        instr_done_o = 1'b1;
      end
      StBranch: begin
        alu_src_a_o  = 2'b10;
        alu_op_o     = 2'b01;
        pc_write_o   = zero_i ^ funct3_i[0];
        instr_done_o = 1'b1;
      end
      StJal: begin
        alu_src_a_o = 2'b01;
        alu_src_b_o = 2'b10;
        pc_write_o  = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    case (op_i)
      OpStore:  imm_src_o = 2'b01;
      OpBranch: imm_src_o = 2'b10;
      OpJal:    imm_src_o = 2'b11;
      default:  imm_src_o = 2'b00;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StRst;
      wait_q    <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      mem_err_q <= mem_err_d;
    end
  end

`ifdef ILLEGAL_OP_TRAP_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= illegal_d;
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomised bench for multicycle_controller: a step-sequence model checked every cycle,
// plus directed scenarios with hand-computed cycle counts.
module tb_multicycle_controller;

  localparam int MaxWait = 15;
`ifdef ILLEGAL_OP_TRAP_EN
  localparam bit Trap = 1'b1;
`else
  localparam bit Trap = 1'b0;
`endif

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;

  // Instruction steps of the model
  localparam int SRst = 0, SF = 1, SD = 2, SMa = 3, SMr = 4, SMwb = 5, SMw = 6;
  localparam int SEr = 7, SEi = 8, SWb = 9, SBr = 10, SJ = 11, SFlt = 12;

  typedef struct packed {
    logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
    logic [1:0] result_src, src_a, src_b, imm, alu_op;
    logic       instr_done;
  } ctl_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [6:0] op;
  logic [2:0] f3;
  logic       zero, rdy;
  logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src, alu_op;
  logic       instr_done, mem_err, illegal_op;

  int checks = 0;
  int failures = 0;

  int m_step = SRst, m_wait = 0, n_step = SRst, n_wait = 0;
  bit m_err = 1'b0, m_ill = 1'b0, n_err = 1'b0, n_ill = 1'b0;

  multicycle_controller #(
    .MEM_WAIT_MAX(MaxWait),
    .WAIT_CNT_W  (4)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .op_i        (op),
    .funct3_i    (f3),
    .zero_i      (zero),
    .mem_ready_i (rdy),
    .mem_req_o   (mem_req),
    .mem_write_o (mem_write),
    .adr_src_o   (adr_src),
    .ir_write_o  (ir_write),
    .pc_write_o  (pc_write),
    .reg_write_o (reg_write),
    .result_src_o(result_src),
    .alu_src_a_o (alu_src_a),
    .alu_src_b_o (alu_src_b),
    .imm_src_o   (imm_src),
    .alu_op_o    (alu_op),
    .instr_done_o(instr_done),
    .mem_err_o   (mem_err),
    .illegal_op_o(illegal_op)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_known(input logic [6:0] o);
    return o inside {OpLoad, OpStore, OpR, OpImm, OpBranch, OpJal};
  endfunction

  function automatic ctl_t model_ctl(input int step, input logic [6:0] o, input logic [2:0] f,
                                     input logic z, input logic r);
    ctl_t c = '0;
    c.imm = (o == OpStore) ? 2'd1 : (o == OpBranch) ? 2'd2 : (o == OpJal) ? 2'd3 : 2'd0;
    case (step)
      SF:   begin c.mem_req = 1; c.src_b = 2; c.result_src = 2; c.ir_write = r; c.pc_write = r; end
      SD:   begin c.src_a = 1; c.src_b = 1; c.instr_done = !Trap && !is_known(o); end
      SMa:  begin c.src_a = 2; c.src_b = 1; end
      SMr:  begin c.mem_req = 1; c.adr_src = 1; end
      SMwb: begin c.result_src = 1; c.reg_write = 1; c.instr_done = 1; end
      SMw:  begin c.mem_req = 1; c.mem_write = 1; c.adr_src = 1; c.instr_done = r; end
      SEr:  begin c.src_a = 2; c.alu_op = 2; end
      SEi:  begin c.src_a = 2; c.src_b = 1; c.alu_op = 2; end
      SWb:  begin c.reg_write = 1; c.instr_done = 1; end
      SBr:  begin c.src_a = 2; c.alu_op = 1; c.pc_write = z ^ f[0]; c.instr_done = 1; end
      SJ:   begin c.src_a = 1; c.src_b = 2; c.pc_write = 1; end
      default: ;
    endcase
    return c;
  endfunction

  // Compare process: checks every cycle and works out the model's next step.
  always @(negedge clk) begin
    ctl_t e, a;
    e = model_ctl(m_step, op, f3, zero, rdy);
    a.mem_req = mem_req; a.mem_write = mem_write; a.adr_src = adr_src; a.ir_write = ir_write;
    a.pc_write = pc_write; a.reg_write = reg_write; a.result_src = result_src;
    a.src_a = alu_src_a; a.src_b = alu_src_b; a.imm = imm_src; a.alu_op = alu_op;
    a.instr_done = instr_done;
    check("ctl", 32'(a), 32'(e));
    check("mem_err", 32'(mem_err), 32'(m_err));
    check("illegal_op", 32'(illegal_op), 32'(m_ill));

    n_step = m_step; n_wait = 0; n_err = m_err; n_ill = m_ill;
    case (m_step)
      SRst: n_step = SF;
      SF, SMr, SMw: begin
        if (rdy) n_step = (m_step == SF) ? SD : (m_step == SMr) ? SMwb : SF;
        else if (MaxWait != 0 && m_wait == MaxWait) begin n_step = SFlt; n_err = 1'b1; end
        else n_wait = m_wait + 1;
      end
      SD: begin
        if (op == OpLoad || op == OpStore) n_step = SMa;
        else if (op == OpR) n_step = SEr;
        else if (op == OpImm) n_step = SEi;
        else if (op == OpBranch) n_step = SBr;
        else if (op == OpJal) n_step = SJ;
        else if (Trap) begin n_step = SFlt; n_ill = 1'b1; end
        else n_step = SF;
      end
      SMa: n_step = op[5] ? SMw : SMr;
      SMwb, SWb, SBr: n_step = SF;
      SEr, SEi, SJ: n_step = SWb;
      default: n_step = SFlt;
    endcase
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_step <= SRst; m_wait <= 0; m_err <= 1'b0; m_ill <= 1'b0;
    end else begin
      m_step <= n_step; m_wait <= n_wait; m_err <= n_err; m_ill <= n_ill;
    end
  end

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic [6:0] o, input logic [2:0] f, input logic z, input logic r);
    op = o; f3 = f; zero = z; rdy = r;
    @(negedge clk);
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int done_at, n, k;
    op = OpR; f3 = 3'b000; zero = 1'b0; rdy = 1'b1;
    #1 rst_n = 1'b0;

    // R-type from reset: RST, FETCH, DECODE, EXECR, ALUWB
    apply_reset();
    done_at = 0; n = 0;
    for (int i = 1; i <= 5; i++) begin
      cyc(OpR, 3'b000, 1'b0, 1'b1);
      if (i == 1) check("reset_outputs", 32'({mem_req, ir_write, pc_write, mem_err}), 32'd0);
      if (instr_done && done_at == 0) done_at = i;
      if (reg_write) n++;
      if (i == 5) check("model_rtype_wb_step", 32'(m_step), 32'(SWb));
      adv();
    end
    check("rtype_done_cycle", 32'(done_at), 32'd5);
    check("rtype_reg_write_count", 32'(n), 32'd1);

    // lw with three wait cycles in MEMREAD
    apply_reset();
    cyc(OpLoad, 3'b010, 1'b0, 1'b1); adv();
    done_at = 0; n = 0;
    for (int i = 1; i <= 8; i++) begin
      cyc(OpLoad, 3'b010, 1'b0, !(i >= 4 && i <= 6));
      if (mem_req && adr_src) n++;
      if (instr_done && done_at == 0) done_at = i;
      if (i == 8) check("lw_writeback", 32'({reg_write, result_src}), 32'b101);
      adv();
    end
    check("lw_done_cycle", 32'(done_at), 32'd8);
    check("lw_memread_cycles", 32'(n), 32'd4);

    // bne taken (zero=0) then not taken (zero=1); now in FETCH
    for (int t = 0; t < 2; t++) begin
      done_at = 0;
      for (int i = 1; i <= 3; i++) begin
        cyc(OpBranch, 3'b001, t[0], 1'b1);
        if (instr_done && done_at == 0) done_at = i;
        if (i == 3) check(t == 0 ? "bne_taken" : "bne_not_taken", 32'(pc_write), t == 0 ? 1 : 0);
        adv();
      end
      check("branch_done_cycle", 32'(done_at), 32'd3);
    end

    // Fetch timeout: 16 stalled FETCH cycles, then FAULT with strobes low
    apply_reset();
    cyc(OpR, 3'b000, 1'b0, 1'b0); adv();
    n = 0;
    for (k = 0; k < 40 && !mem_err; k++) begin
      cyc(OpR, 3'b000, 1'b0, 1'b0);
      if (mem_req) n++;
      adv();
    end
    check("timeout_fetch_cycles", 32'(n), 32'd16);
    check("model_timeout_err", 32'(m_err), 32'd1);
    for (int i = 0; i < 4; i++) begin
      cyc(OpStore, 3'b000, 1'b1, 1'b1);
      check("fault_strobes", 32'({mem_req, mem_write, ir_write, pc_write, reg_write, instr_done}), 0);
      check("fault_mem_err", 32'(mem_err), 32'd1);
      adv();
    end

    // Unrecognised opcode
    apply_reset();
    cyc(7'h7f, 3'b000, 1'b0, 1'b1); adv();
    cyc(7'h7f, 3'b000, 1'b0, 1'b1); adv();
    cyc(7'h7f, 3'b000, 1'b0, 1'b1);
    check("illegal_decode_done", 32'(instr_done), 32'(!Trap));
    adv();
    cyc(OpR, 3'b000, 1'b0, 1'b1);
    check("illegal_after", 32'({mem_req, illegal_op, mem_err}), 32'({!Trap, Trap, 1'b0}));
    adv();

    // Reset asserted during a stalled store
    apply_reset();
    cyc(OpStore, 3'b010, 1'b0, 1'b1); adv();
    for (int i = 1; i <= 5; i++) begin
      cyc(OpStore, 3'b010, 1'b0, i < 4);
      if (i == 5) check("sw_write_held", 32'(mem_write), 32'd1);
      if (i < 5) adv();
    end
    #2 rst_n = 1'b0;
    #1 check("sw_reset_drop", 32'({mem_write, mem_req}), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc(OpStore, 3'b010, 1'b0, 1'b1);
    check("sw_restart_rst", 32'(mem_req), 32'd0);
    adv();
    cyc(OpStore, 3'b010, 1'b0, 1'b1);
    check("sw_restart_fetch", 32'({mem_req, adr_src}), 32'b10);
    adv();

    // Randomised run checked by the compare process
    for (int i = 0; i < 3000; i++) begin
      logic [6:0] o;
      case ($urandom_range(0, 19))
        0: o = 7'($urandom);
        1, 2, 3: o = OpLoad;
        4, 5, 6: o = OpStore;
        7, 8, 9: o = OpR;
        10, 11, 12: o = OpImm;
        13, 14, 15: o = OpBranch;
        default: o = OpJal;
      endcase
      if (m_step == SFlt || $urandom_range(0, 399) == 0) apply_reset();
      cyc(o, 3'($urandom), 1'($urandom), $urandom_range(0, 3) != 0);
      adv();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Main control FSM for the multicycle RV32I core variant.
- Sequences the shared ALU, register file, instruction register and unified memory through fetch, decode, execute, memory and writeback steps.
- Drives the 2-bit ALUOp into the existing ALU decoder; does not generate ALUControl itself.
- Adds a req/ready memory handshake with a wait-timeout watchdog.

Parameters:
- MEM_WAIT_MAX, 15, max cycles mem_req may wait for mem_ready before fault; 0 disables the timeout.
- WAIT_CNT_W, 4, width of the wait counter; must satisfy 2^WAIT_CNT_W > MEM_WAIT_MAX.

Ports:
- clk  in  1  core clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- op  in  7  instruction[6:0] from IR.
- funct3  in  3  instruction[14:12]; used for branch sense only.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory accepts the write / returns read data this cycle.
- mem_req  out  1  memory access request.
- mem_write  out  1  write strobe.
- adr_src  out  1  0=PC, 1=Result.
- ir_write  out  1  latch instruction and OldPC.
- pc_write  out  1  load PC from Result.
- reg_write  out  1  register file write.
- result_src  out  2  00=ALUOut, 01=Data, 10=ALUResult.
- alu_src_a  out  2  00=PC, 01=OldPC, 10=rs1 register.
- alu_src_b  out  2  00=rs2 register, 01=ImmExt, 10=constant 4.
- imm_src  out  2  00=I, 01=S, 10=B, 11=J; combinational from op.
- alu_op  out  2  to ALU decoder: 00=add, 01=sub, 10=funct-decoded.
- instr_done  out  1  one-cycle pulse on the final cycle of each instruction.
- mem_err  out  1  sticky memory timeout fault.
- illegal_op  out  1  sticky illegal opcode flag.

Behaviour:
- States: RST, FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, FAULT.
- Async reset_n low: state=RST, wait counter=0, mem_err=0, illegal_op=0.
- RST: all outputs 0 except imm_src. Next state FETCH unconditionally.
- Control outputs are Moore-decoded from state, except the FETCH/MEMREAD/MEMWRITE strobes, which are qualified by mem_ready.
- FETCH: mem_req=1, adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10.
  - ir_write=pc_write=mem_ready.
  - Stays in FETCH until mem_ready=1, then goes to DECODE.
- DECODE: alu_src_a=01, alu_src_b=01, alu_op=00 (branch target into ALUOut). Next state by op:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - any other op -> see Optional Feature.
- MEMADR: alu_src_a=10, alu_src_b=01, alu_op=00. Next state MEMREAD if op[5]=0, else MEMWRITE.
- MEMREAD: mem_req=1, adr_src=1, result_src=00. Waits for mem_ready, then MEMWB.
- MEMWB: result_src=01, reg_write=1, instr_done=1. Next FETCH.
- MEMWRITE: mem_req=1, mem_write=1, adr_src=1, result_src=00.
  - mem_write is held for the entire wait; the memory commits only on the mem_ready cycle.
  - On mem_ready: instr_done=1, next FETCH.
- EXECR: alu_src_a=10, alu_src_b=00, alu_op=10. Next ALUWB.
- EXECI: alu_src_a=10, alu_src_b=01, alu_op=10. Next ALUWB.
- ALUWB: result_src=00, reg_write=1, instr_done=1. Next FETCH.
- BRANCH: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00.
  - pc_write = zero XOR funct3[0] (beq/bne).
  - instr_done=1, next FETCH.
- JAL: alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_write=1. Next ALUWB.
- Latency with zero-wait memory: lw 5, sw 4, R 4, I 4, branch 3, jal 4 cycles. Each memory wait cycle adds one.
- Wait counter:
  - Clears on entry to any mem_req state and when mem_ready=1.
  - Increments each cycle mem_req=1 and mem_ready=0.
  - If MEM_WAIT_MAX!=0 and the counter equals MEM_WAIT_MAX with mem_ready still 0: next state FAULT, mem_err set.
  - mem_ready in that same cycle wins over the timeout.
- FAULT: all strobes and mem_req 0; held until reset_n. mem_err/illegal_op are cleared only by reset.
- Reset mid-instruction: immediate return to RST; no partial strobe may follow.
- imm_src is always decoded from op (sw->01, branch->10, jal->11, else 00).

Optional Feature:
- Macro: ILLEGAL_OP_TRAP_EN.
- Defined: an unrecognised op in DECODE goes to FAULT and sets illegal_op.
- Undefined: an unrecognised op is a NOP. DECODE goes to FETCH with instr_done=1, and illegal_op is tied 0.
- Both builds: PC has already advanced by 4 in FETCH.

Test Plan:
- Reset release, mem_ready=1, op=0110011 -> sequence RST,FETCH,DECODE,EXECR,ALUWB; reg_write=1 only in ALUWB; instr_done once.
- lw with mem_ready=0 for 3 cycles in MEMREAD -> MEMREAD held 4 cycles; total 8 cycles; reg_write=1, result_src=01 in MEMWB.
- op=1100011, funct3=001, zero=0 -> pc_write=1 in BRANCH; repeat with zero=1 -> pc_write=0.
- MEM_WAIT_MAX=15, mem_ready stuck 0 in FETCH -> FAULT after 16 FETCH cycles, mem_err=1, all strobes 0 until reset_n.
- op=1111111 -> with ILLEGAL_OP_TRAP_EN: FAULT, illegal_op=1; without it: back to FETCH after DECODE, illegal_op=0.
- reset_n asserted during MEMWRITE wait -> mem_write drops to 0 immediately; restart in RST then FETCH.
